// File: rtl/miller_decoder.sv
// Miller (delay-modulation) line decoder: synchronise, hunt for bit phase, track a half-bit grid.
// Optional Miller coding-rule check is built in when RULE_CHECK_EN is defined.
module miller_decoder #(
  parameter int HALF_BIT_CYCLES = 16,
  parameter int TOL             = 3
) (
  input  logic clk_100m,
  input  logic rst_n,
  input  logic miller_i,
  output logic bit_o,
  output logic bit_valid_o,
  output logic locked_o,
  output logic err_o
);

  localparam int CW = $clog2(HALF_BIT_CYCLES);
  localparam int IW = $clog2(4 * HALF_BIT_CYCLES + 2 * TOL + 2) + 1;

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(HALF_BIT_CYCLES - 1);
  localparam logic [CW-1:0] LATE_MAX  = CW'(TOL);
  localparam logic [CW-1:0] EARLY_MIN = CW'(HALF_BIT_CYCLES - TOL);
  localparam logic [CW-1:0] DECIDE_AT = CW'(TOL + 1);
  localparam logic [IW-1:0] IVL_ONE   = IW'(1);
  localparam logic [IW-1:0] IVL_SAT   = {IW{1'b1}};
  localparam logic [IW-1:0] LOCK_MIN  = IW'(4 * HALF_BIT_CYCLES - TOL);
  localparam logic [IW-1:0] LOCK_MAX  = IW'(4 * HALF_BIT_CYCLES + TOL);
  localparam logic [2:0]    HB_LIMIT  = 3'd4;

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [2:0]    sync_q;
  logic [IW-1:0] ivl_q, ivl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;       // 1 = second half of the bit
  logic [2:0]    hb_q, hb_d;
  logic          mid_seen_q, mid_seen_d;
  logic          bit_q, bit_d;
  logic          valid_q, valid_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic          edge_det, viol, grid_mid;
`ifdef RULE_CHECK_EN
  logic          bnd_seen_q, bnd_seen_d;
  logic          prev_bit_q, prev_bit_d;
  logic          prev_bnd_q, prev_bnd_d;
`endif

  assign edge_det = sync_q[1] ^ sync_q[2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    hb_d       = hb_q;
    mid_seen_d = mid_seen_q;
    bit_d      = bit_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    viol       = 1'b0;
    grid_mid   = 1'b0;
`ifdef RULE_CHECK_EN
    bnd_seen_d = bnd_seen_q;
    prev_bit_d = prev_bit_q;
    prev_bnd_d = prev_bnd_q;
`endif
    if (edge_det) begin
      ivl_d = IVL_ONE;
    end else if (ivl_q != IVL_SAT) begin
      ivl_d = ivl_q + IVL_ONE;
    end else begin
      ivl_d = ivl_q;
    end

    case (state_q)
      HUNT: begin
        // Only a 4-half-bit interval (data 1,0,1) pins the phase: both its edges are mid-bit.
        if (edge_det && (ivl_q >= LOCK_MIN) && (ivl_q <= LOCK_MAX)) begin
          state_d    = LOCKED;
          cnt_d      = CNT_ONE;
          phase_d    = 1'b1;
          hb_d       = 3'd0;
          mid_seen_d = 1'b1;
`ifdef RULE_CHECK_EN
          bnd_seen_d = 1'b0;
          prev_bit_d = 1'b1;
          prev_bnd_d = 1'b1;
`endif
        end else begin
          state_d = HUNT;
        end
      end
      LOCKED: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
          hb_d    = (hb_q != HB_LIMIT) ? hb_q + 3'd1 : hb_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
        // The edge cycle itself is grid point 0, so the next cycle counts 1.
        if (edge_det) begin
          cnt_d = CNT_ONE;
          hb_d  = 3'd0;
          if (cnt_q <= LATE_MAX) begin
            phase_d  = phase_q;
            grid_mid = phase_q;
          end else if (cnt_q >= EARLY_MIN) begin
            phase_d  = ~phase_q;
            grid_mid = ~phase_q;
          end else begin
            viol = 1'b1;
          end
          if (grid_mid) begin
            mid_seen_d = 1'b1;
          end else begin
`ifdef RULE_CHECK_EN
            bnd_seen_d = ~viol;
`else
            mid_seen_d = mid_seen_q;
`endif
          end
        end
        if (!phase_q && (cnt_q == DECIDE_AT)) begin
          valid_d    = 1'b1;
          bit_d      = mid_seen_q;
          mid_seen_d = 1'b0;
`ifdef RULE_CHECK_EN
          // Boundary edge after a 1, or no boundary edge between two 0s.
          if ((mid_seen_q && bnd_seen_q) || (!mid_seen_q && !prev_bit_q && !prev_bnd_q)) begin
            viol = 1'b1;
          end else begin
            viol = viol;
          end
          prev_bit_d = mid_seen_q;
          prev_bnd_d = bnd_seen_q;
          bnd_seen_d = 1'b0;
`endif
        end
        if ((hb_q == HB_LIMIT) && (cnt_q > LATE_MAX)) begin
          viol = 1'b1;
        end
        if (viol) begin
          state_d    = HUNT;
          err_d      = 1'b1;
          cnt_d      = '0;
          phase_d    = 1'b0;
          hb_d       = 3'd0;
          mid_seen_d = 1'b0;
`ifdef RULE_CHECK_EN
          bnd_seen_d = 1'b0;
`endif
        end else begin
          state_d = LOCKED;
        end
      end
      default: state_d = HUNT;
    endcase
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      sync_q     <= 3'b000;
      ivl_q      <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      hb_q       <= 3'd0;
      mid_seen_q <= 1'b0;
      bit_q      <= 1'b0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
`ifdef RULE_CHECK_EN
      bnd_seen_q <= 1'b0;
      prev_bit_q <= 1'b0;
      prev_bnd_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[1:0], miller_i};
      ivl_q      <= ivl_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      hb_q       <= hb_d;
      mid_seen_q <= mid_seen_d;
      bit_q      <= bit_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
`ifdef RULE_CHECK_EN
      bnd_seen_q <= bnd_seen_d;
      prev_bit_q <= prev_bit_d;
      prev_bnd_q <= prev_bnd_d;
`endif
    end
  end

  assign bit_o       = bit_q;
  assign bit_valid_o = valid_q;
  assign locked_o    = locked_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_miller_decoder.sv
// Directed bench for miller_decoder (HALF_BIT_CYCLES=16, TOL=3); expectations follow RULE_CHECK_EN.
module tb_miller_decoder;
  logic clk_100m = 1'b0;
  logic rst_n;
  logic miller_i;
  logic bit_o, bit_valid_o, locked_o, err_o;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic str_bits[$];
  int   str_cyc[$];
  int   err_cyc[$];
  int   rise_cyc[$];
  logic locked_prev = 1'b0;

  // Pin toggle (driven just after posedge n) to registered output: 2 sync stages + output flop.
  localparam int PIPE = 3;

  miller_decoder #(.HALF_BIT_CYCLES(16), .TOL(3)) dut (
    .clk_100m    (clk_100m),
    .rst_n       (rst_n),
    .miller_i    (miller_i),
    .bit_o       (bit_o),
    .bit_valid_o (bit_valid_o),
    .locked_o    (locked_o),
    .err_o       (err_o)
  );

  always #5 clk_100m = ~clk_100m;

  always @(posedge clk_100m) cyc <= cyc + 1;

  always @(negedge clk_100m) begin
    if (bit_valid_o) begin
      str_bits.push_back(bit_o);
      str_cyc.push_back(cyc);
    end
    if (err_o) err_cyc.push_back(cyc);
    if (locked_o && !locked_prev) rise_cyc.push_back(cyc);
    locked_prev <= locked_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic toggle_at(input int t);
    while (cyc < t) @(negedge clk_100m);
    miller_i = ~miller_i;
  endtask

  // Miller-encode data[nbits-1:0] LSB first; optional edge jitter, one +5 edge, one injected boundary edge.
  task automatic play(input logic [15:0] data, input int nbits, input int jit, input int bad_edge,
                      input int inj_bit, output int t0, output int t_last);
    int   times[$];
    logic prev, cur;
    int   k;
    t0   = cyc + 20;
    prev = 1'b1;
    k    = t0;
    for (int i = 0; i < nbits; i++) begin
      cur = data[i];
      if ((i > 0 && !prev && !cur) || i == inj_bit) times.push_back(t0 + i * 32);
      if (cur) times.push_back(t0 + i * 32 + 16);
      prev = cur;
    end
    for (int j = 0; j < times.size(); j++) begin
      k = times[j];
      if (jit != 0) k = k + ((j % 4 == 1) ? 3 : ((j % 4 == 3) ? -3 : 0));
      if (j == bad_edge) k = k + 5;
      toggle_at(k);
    end
    t_last = k;
    repeat (100) @(negedge clk_100m);
  endtask

  task automatic check_stream(input string tag, input int base, input logic [15:0] exp, input int n);
    check($sformatf("%s_count", tag), str_bits.size() - base, n);
    for (int i = 0; i < n && base + i < str_bits.size(); i++)
      check($sformatf("%s_bit%0d", tag, i), {31'd0, str_bits[base + i]}, {31'd0, exp[i]});
  endtask

  task automatic check_err(input string tag, input int base, input int t);
    check($sformatf("%s_err_count", tag), err_cyc.size() - base, 1);
    if (t >= 0 && err_cyc.size() > base) check($sformatf("%s_err_time", tag), err_cyc[base], t);
    check($sformatf("%s_unlocked", tag), {31'd0, locked_o}, 0);
  endtask

  initial begin
    int t0, tl, t, sb, eb, rb;
    rst_n    = 1'b0;
    miller_i = 1'b0;
    repeat (5) @(negedge clk_100m);
    check("rst_bit", {31'd0, bit_o}, 0);
    check("rst_valid", {31'd0, bit_valid_o}, 0);
    check("rst_locked", {31'd0, locked_o}, 0);
    check("rst_err", {31'd0, err_o}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_100m);

    // Ideal 1,0,1,1,0,0,1: lock on the 64-cycle interval, then the idle bit before timeout decodes as 0.
    sb = str_bits.size(); eb = err_cyc.size(); rb = rise_cyc.size();
    play(16'd77, 7, 0, -1, -1, t0, tl);
    check("ideal_rise_count", rise_cyc.size() - rb, 1);
    if (rise_cyc.size() > rb) check("ideal_rise_time", rise_cyc[rb], t0 + 80 + PIPE);
    check_stream("ideal", sb, 16'h0013, 6);
    for (int i = 0; i < 6 && sb + i < str_cyc.size(); i++)
      check($sformatf("ideal_strobe%0d_time", i), str_cyc[sb + i], t0 + 96 + 32 * i + 4 + PIPE);
    check_err("ideal_timeout", eb, tl + 64 + 4 + PIPE);

    // Same stream, intervals jittered by +/-3 cycles.
    sb = str_bits.size(); eb = err_cyc.size();
    play(16'd77, 7, 1, -1, -1, t0, tl);
    check_stream("jitter", sb, 16'h0013, 6);
    check_err("jitter_timeout", eb, tl + 64 + 4 + PIPE);

    // Bit-3 mid edge late by 5: violation 37 cycles after the lock edge.
    sb = str_bits.size(); eb = err_cyc.size();
    play(16'd77, 7, 0, 2, -1, t0, tl);
    check_stream("late5", sb, 16'h0001, 1);
    check_err("late5", eb, t0 + 117 + PIPE);

    // Lock, eight 0 bits with boundary edges, a closing 1, then idle.
    sb = str_bits.size(); eb = err_cyc.size();
    play(16'd2053, 12, 0, -1, -1, t0, tl);
    check_stream("zeros", sb, 16'h0201, 11);
    check_err("zeros_timeout", eb, tl + 64 + 4 + PIPE);

    // Boundary edge injected at the start of bit 4, right after the 1 in bit 3.
    sb = str_bits.size(); eb = err_cyc.size();
    play(16'd29, 5, 0, -1, 4, t0, tl);
`ifdef RULE_CHECK_EN
    check_stream("inject", sb, 16'h0003, 2);
    check_err("inject_rule", eb, t0 + 128 + 4 + PIPE);
`else
    check_stream("inject", sb, 16'h0007, 4);
    check_err("inject_timeout", eb, tl + 64 + 4 + PIPE);
`endif

    // Reset mid-stream while locked and toggling; no relock until a fresh 64-cycle interval.
    t = cyc + 20;
    toggle_at(t);
    toggle_at(t + 64);
    toggle_at(t + 96);
    toggle_at(t + 128);
    while (cyc < t + 140) @(negedge clk_100m);
    check("pre_reset_locked", {31'd0, locked_o}, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_bit", {31'd0, bit_o}, 0);
    check("midrst_valid", {31'd0, bit_valid_o}, 0);
    check("midrst_locked", {31'd0, locked_o}, 0);
    check("midrst_err", {31'd0, err_o}, 0);
    toggle_at(t + 160);
    toggle_at(t + 192);
    while (cyc < t + 200) @(negedge clk_100m);
    rst_n = 1'b1;
    sb = str_bits.size(); eb = err_cyc.size(); rb = rise_cyc.size();
    toggle_at(t + 224);
    toggle_at(t + 256);
    toggle_at(t + 288);
    toggle_at(t + 320);
    while (cyc < t + 380) @(negedge clk_100m);
    check("postrst_no_rise", rise_cyc.size() - rb, 0);
    check("postrst_no_strobe", str_bits.size() - sb, 0);
    check("postrst_no_err", err_cyc.size() - eb, 0);
    toggle_at(t + 384);
    while (cyc < t + 390) @(negedge clk_100m);
    check("relock_rise_count", rise_cyc.size() - rb, 1);
    if (rise_cyc.size() > rb) check("relock_rise_time", rise_cyc[rb], t + 384 + PIPE);
    check("relock_locked", {31'd0, locked_o}, 1);
    repeat (100) @(negedge clk_100m);
    check_err("relock_timeout", eb, t + 384 + 64 + 4 + PIPE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
